// File: rtl/tl_ul_ram_responder.sv
// -----------------------------------------------------------------------------
// tl_ul_ram_responder
//
// TileLink-UL manager that terminates a narrowed A/D link (64-bit beats,
// 7-bit source, 28-bit address) with a register-array RAM of DEPTH 64-bit
// words. Get returns AccessAckData with the full word. PutFull/PutPartial
// write the masked byte lanes and return AccessAck. Corrupt Puts and
// unsupported opcodes write nothing and return AccessAck with zero data.
// Responses come out of a single-entry D register: one-cycle latency, one
// request per cycle while D is drained.
//
// Ports
//   clock                  sole clock, rising edge
//   reset                  asynchronous, active-low
//   auto_in_a_*            A channel (request) in; a_ready out
//   auto_in_d_*            D channel (response) out; d_ready in
//
// Parameters
//   DEPTH  number of 64-bit words (power of two, >= 2)
//   BASE   region base; address bits above the word index are ignored,
//          so the region aliases throughout the address space
// -----------------------------------------------------------------------------
module tl_ul_ram_responder #(
    parameter int unsigned DEPTH = 512,
    parameter logic [27:0] BASE  = 28'h0
) (
    input  logic        clock,
    input  logic        reset,
    // A channel
    output logic        auto_in_a_ready,
    input  logic        auto_in_a_valid,
    input  logic [2:0]  auto_in_a_bits_opcode,
    input  logic [2:0]  auto_in_a_bits_param,
    input  logic [1:0]  auto_in_a_bits_size,
    input  logic [6:0]  auto_in_a_bits_source,
    input  logic [27:0] auto_in_a_bits_address,
    input  logic [7:0]  auto_in_a_bits_mask,
    input  logic [63:0] auto_in_a_bits_data,
    input  logic        auto_in_a_bits_corrupt,
    // D channel
    input  logic        auto_in_d_ready,
    output logic        auto_in_d_valid,
    output logic [2:0]  auto_in_d_bits_opcode,
    output logic [1:0]  auto_in_d_bits_size,
    output logic [6:0]  auto_in_d_bits_source,
    output logic [63:0] auto_in_d_bits_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic [2:0] {
        A_PUT_FULL    = 3'd0,
        A_PUT_PARTIAL = 3'd1,
        A_GET         = 3'd4
    } a_op_e;

    typedef enum logic [2:0] {
        D_ACCESS_ACK      = 3'd0,
        D_ACCESS_ACK_DATA = 3'd1
    } d_op_e;

    // -------------------------------------------------------------------------
    // Storage and response register
    // -------------------------------------------------------------------------
    logic [63:0]      mem_q [DEPTH];

    logic             d_valid_q,  d_valid_d;
    d_op_e            d_opcode_q, d_opcode_d;
    logic [1:0]       d_size_q,   d_size_d;
    logic [6:0]       d_source_q, d_source_d;
    logic [63:0]      d_data_q,   d_data_d;

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] word_idx;
    logic             a_fire;
    logic             is_get;
    logic             is_put;
    logic             wr_en;

    assign word_idx = auto_in_a_bits_address[3 +: IDX_W];

    // The D register is free if empty or being drained this very cycle.
    assign auto_in_a_ready = !d_valid_q || auto_in_d_ready;
    assign a_fire          = auto_in_a_valid && auto_in_a_ready;

    assign is_get = (auto_in_a_bits_opcode == A_GET);
    assign is_put = (auto_in_a_bits_opcode == A_PUT_FULL) ||
                    (auto_in_a_bits_opcode == A_PUT_PARTIAL);
    // Poisoned write data must never reach the array.
    assign wr_en  = a_fire && is_put && !auto_in_a_bits_corrupt;

    // -------------------------------------------------------------------------
    // RAM write port
    // NOTE: the array has no reset on purpose -- contents survive reset and a
    // reset branch would force it into individual flops with reset routing.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (auto_in_a_bits_mask[i]) begin
                    mem_q[word_idx][8*i +: 8] <= auto_in_a_bits_data[8*i +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // D response next-state
    // NOTE: every _d signal takes its hold value first, so no path through
    // this block leaves a signal unassigned and no latch is inferred.
    // -------------------------------------------------------------------------
    always_comb begin
        d_valid_d  = d_valid_q;
        d_opcode_d = d_opcode_q;
        d_size_d   = d_size_q;
        d_source_d = d_source_q;
        d_data_d   = d_data_q;

        if (a_fire) begin
            // Read sees the array before this edge's write; a Get and a Put
            // are never the same request, so no bypass is needed.
            d_valid_d  = 1'b1;
            d_opcode_d = is_get ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
            d_size_d   = auto_in_a_bits_size;
            d_source_d = auto_in_a_bits_source;
            d_data_d   = is_get ? mem_q[word_idx] : 64'h0;
        end else if (auto_in_d_ready) begin
            d_valid_d  = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            d_valid_q  <= 1'b0;
            d_opcode_q <= D_ACCESS_ACK;
            d_size_q   <= 2'd0;
            d_source_q <= 7'd0;
            d_data_q   <= 64'h0;
        end else begin
            d_valid_q  <= d_valid_d;
            d_opcode_q <= d_opcode_d;
            d_size_q   <= d_size_d;
            d_source_q <= d_source_d;
            d_data_q   <= d_data_d;
        end
    end

    assign auto_in_d_valid       = d_valid_q;
    assign auto_in_d_bits_opcode = d_opcode_q;
    assign auto_in_d_bits_size   = d_size_q;
    assign auto_in_d_bits_source = d_source_q;
    assign auto_in_d_bits_data   = d_data_q;

    // Inputs that carry no meaning here: param, the ignored address bits and
    // the base (the region aliases, so BASE never alters the index).
    logic unused_inputs;
    assign unused_inputs = ^{auto_in_a_bits_param, auto_in_a_bits_address, BASE};

endmodule

// File: tb/tb_tl_ul_ram_responder.sv
// -----------------------------------------------------------------------------
// tb_tl_ul_ram_responder
//
// Directed bench for tl_ul_ram_responder. The driver pushes the hand-computed
// expected response into a scoreboard queue the moment a request is accepted;
// an independent monitor pops and compares every D handshake, and checks that
// each response first appears the cycle after its request was accepted.
// -----------------------------------------------------------------------------
module tb_tl_ul_ram_responder;

    logic        clock;
    logic        reset;
    logic        a_ready;
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [6:0]  a_source;
    logic [27:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        a_corrupt;
    logic        d_ready;
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [1:0]  d_size;
    logic [6:0]  d_source;
    logic [63:0] d_data;

    tl_ul_ram_responder dut (
        .clock                  (clock),
        .reset                  (reset),
        .auto_in_a_ready        (a_ready),
        .auto_in_a_valid        (a_valid),
        .auto_in_a_bits_opcode  (a_opcode),
        .auto_in_a_bits_param   (a_param),
        .auto_in_a_bits_size    (a_size),
        .auto_in_a_bits_source  (a_source),
        .auto_in_a_bits_address (a_address),
        .auto_in_a_bits_mask    (a_mask),
        .auto_in_a_bits_data    (a_data),
        .auto_in_a_bits_corrupt (a_corrupt),
        .auto_in_d_ready        (d_ready),
        .auto_in_d_valid        (d_valid),
        .auto_in_d_bits_opcode  (d_opcode),
        .auto_in_d_bits_size    (d_size),
        .auto_in_d_bits_source  (d_source),
        .auto_in_d_bits_data    (d_data)
    );

    localparam logic [2:0] PUT_FULL = 3'd0;
    localparam logic [2:0] PUT_PART = 3'd1;
    localparam logic [2:0] GET      = 3'd4;
    localparam logic [2:0] ACK      = 3'd0;
    localparam logic [2:0] ACK_DATA = 3'd1;

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [6:0]  src;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp     = 0;
    int   n_err     = 0;
    int   cyc       = 0;
    bit   presented = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one request and hold it until accepted; a_valid stays high on
    // return so back-to-back calls stream one request per cycle.
    task automatic issue(input logic [2:0] op, input logic [1:0] size, input logic [6:0] src,
                         input logic [27:0] addr, input logic [7:0] mask, input logic [63:0] data,
                         input logic corrupt, input logic [2:0] exp_op, input logic [63:0] exp_data);
        exp_t e;
        bit   done = 0;
        a_valid   = 1'b1;
        a_opcode  = op;
        a_size    = size;
        a_source  = src;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        a_corrupt = corrupt;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clock);
            if (a_ready) begin
                e.op   = exp_op;
                e.size = size;
                e.src  = src;
                e.data = exp_data;
                e.cyc  = cyc;
                sb.push_back(e);
                done = 1;
            end
            @(posedge clock);
            #1;
        end
        if (!done) check("a_ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic req(input logic [2:0] op, input logic [1:0] size, input logic [6:0] src,
                       input logic [27:0] addr, input logic [7:0] mask, input logic [63:0] data,
                       input logic corrupt, input logic [2:0] exp_op, input logic [63:0] exp_data);
        issue(op, size, src, addr, mask, data, corrupt, exp_op, exp_data);
        a_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
            presented = 0;
        end
    endtask

    // Monitor: latency on first appearance, full compare on each D handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (d_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_d_valid", 64'd1, 64'd0);
                end else begin
                    e = sb[0];
                    if (!presented) begin
                        check("latency", 64'(cyc), 64'(e.cyc + 1));
                        presented = 1;
                    end
                    if (d_ready === 1'b1) begin
                        check("d_opcode", 64'(d_opcode), 64'(e.op));
                        check("d_size",   64'(d_size),   64'(e.size));
                        check("d_source", 64'(d_source), 64'(e.src));
                        check("d_data",   d_data,        e.data);
                        void'(sb.pop_front());
                        presented = 0;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        reset     = 1'b0;
        a_valid   = 1'b0;
        a_opcode  = 3'd0;
        a_param   = 3'd0;
        a_size    = 2'd0;
        a_source  = 7'd0;
        a_address = 28'd0;
        a_mask    = 8'd0;
        a_data    = 64'd0;
        a_corrupt = 1'b0;
        d_ready   = 1'b1;

        // Reset state
        #3;
        check("rst_d_valid",  64'(d_valid),  64'd0);
        check("rst_d_opcode", 64'(d_opcode), 64'd0);
        check("rst_d_size",   64'(d_size),   64'd0);
        check("rst_d_source", 64'(d_source), 64'd0);
        check("rst_d_data",   d_data,        64'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        #1 check("post_rst_a_ready", 64'(a_ready), 64'd1);

        // Put then Get
        req(PUT_FULL, 2'd3, 7'd5, 28'h40, 8'hFF, 64'h1122334455667788, 1'b0, ACK, 64'd0);
        req(GET,      2'd3, 7'd9, 28'h40, 8'hFF, 64'd0,                1'b0, ACK_DATA, 64'h1122334455667788);

        // Partial writes, sub-word offset ignored, aliasing above the index
        req(PUT_FULL, 2'd3, 7'd1, 28'h80, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, ACK, 64'd0);
        req(PUT_PART, 2'd3, 7'd2, 28'h80, 8'h0F, 64'd0,                   1'b0, ACK, 64'd0);
        req(GET,      2'd3, 7'd3, 28'h80, 8'h00, 64'd0,                   1'b0, ACK_DATA, 64'hFFFF_FFFF_0000_0000);
        req(PUT_PART, 2'd2, 7'd4, 28'h84, 8'hF0, 64'h1234_5678_0000_0000, 1'b0, ACK, 64'd0);
        req(GET,      2'd0, 7'd6, 28'h1080, 8'h01, 64'd0,                 1'b0, ACK_DATA, 64'h1234_5678_0000_0000);
        drain();

        // Back-pressure: response held, no new request accepted or written
        d_ready = 1'b0;
        req(GET, 2'd3, 7'd12, 28'h80, 8'hFF, 64'd0, 1'b0, ACK_DATA, 64'h1234_5678_0000_0000);
        a_valid   = 1'b1;
        a_opcode  = PUT_FULL;
        a_address = 28'h80;
        a_mask    = 8'hFF;
        a_data    = 64'hDEAD_BEEF_DEAD_BEEF;
        a_source  = 7'd13;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("bp_d_valid",  64'(d_valid),  64'd1);
            check("bp_d_data",   d_data,        64'h1234_5678_0000_0000);
            check("bp_d_source", 64'(d_source), 64'd12);
            check("bp_a_ready",  64'(a_ready),  64'd0);
        end
        @(posedge clock);
        #1;
        a_valid = 1'b0;
        d_ready = 1'b1;
        #1 check("bp_release_a_ready", 64'(a_ready), 64'd1);
        drain();
        req(GET, 2'd3, 7'd14, 28'h80, 8'hFF, 64'd0, 1'b0, ACK_DATA, 64'h1234_5678_0000_0000);

        // Streaming: 16 Puts then 16 Gets, one per cycle
        c0 = cyc;
        for (int i = 0; i < 16; i++)
            issue(PUT_FULL, 2'd3, 7'(32 + i), 28'h200 + 28'(8 * i), 8'hFF,
                  {16'hBEEF, 16'(i), 32'hCAFE_0000 + 32'(i)}, 1'b0, ACK, 64'd0);
        for (int i = 0; i < 16; i++)
            issue(GET, 2'd3, 7'(64 + i), 28'h200 + 28'(8 * i), 8'hFF, 64'd0, 1'b0, ACK_DATA,
                  {16'hBEEF, 16'(i), 32'hCAFE_0000 + 32'(i)});
        a_valid = 1'b0;
        check("stream_cycles", 64'(cyc - c0), 64'd32);
        drain();

        // Corrupt Put and unsupported opcodes leave the word untouched
        req(PUT_FULL, 2'd3, 7'd20, 28'h40, 8'hFF, 64'd0,                 1'b1, ACK, 64'd0);
        req(GET,      2'd3, 7'd21, 28'h40, 8'hFF, 64'd0,                 1'b0, ACK_DATA, 64'h1122334455667788);
        req(3'd2,     2'd3, 7'd22, 28'h40, 8'hFF, 64'hDEAD_DEAD_DEAD_DEAD, 1'b0, ACK, 64'd0);
        req(3'd3,     2'd1, 7'd23, 28'h40, 8'hFF, 64'hDEAD_DEAD_DEAD_DEAD, 1'b0, ACK, 64'd0);
        req(3'd7,     2'd3, 7'd24, 28'h40, 8'hFF, 64'hDEAD_DEAD_DEAD_DEAD, 1'b0, ACK, 64'd0);
        req(GET,      2'd3, 7'd25, 28'h40, 8'hFF, 64'd0,                 1'b0, ACK_DATA, 64'h1122334455667788);
        drain();

        // Reset while a response is held
        d_ready = 1'b0;
        req(GET, 2'd3, 7'd30, 28'h40, 8'hFF, 64'd0, 1'b0, ACK_DATA, 64'h1122334455667788);
        @(negedge clock);
        check("pre_rst_d_valid", 64'(d_valid), 64'd1);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_d_valid",  64'(d_valid),  64'd0);
        check("mid_rst_d_data",   d_data,        64'd0);
        check("mid_rst_d_source", 64'(d_source), 64'd0);
        sb.delete();
        presented = 0;
        @(posedge clock);
        #1;
        reset   = 1'b1;
        d_ready = 1'b1;
        #1 check("rst2_a_ready", 64'(a_ready), 64'd1);
        req(GET, 2'd3, 7'd31, 28'h40, 8'hFF, 64'd0, 1'b0, ACK_DATA, 64'h1122334455667788);
        req(GET, 2'd3, 7'd32, 28'h80, 8'hFF, 64'd0, 1'b0, ACK_DATA, 64'h1234_5678_0000_0000);
        drain();
        repeat (2) @(posedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
